// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and baud counter width.
// Used by the transmit drain and reusable by a matching receiver.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_BAUD_W    = 24;

    // 100 MHz system clock at 115200 baud.
    localparam logic [UART_BAUD_W-1:0] DEFAULT_CLOCKS_PER_BAUD = 24'd868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY
    } uart_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-time counter: loads RELOAD on i_load, counts down to 0 and holds there.
// o_tick is high while the count is 0, i.e. on the last cycle of each bit.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter logic [UART_BAUD_W-1:0] RELOAD = DEFAULT_CLOCKS_PER_BAUD - 24'd1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_tick
);

    localparam logic [UART_BAUD_W-1:0] ONE = 1;

    logic [UART_BAUD_W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else if (i_load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign o_tick = (count == '0);

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from the TX FIFO and serialises them LSB first as 8N1, back to back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter logic [UART_BAUD_W-1:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_empty_n,
    input  logic [7:0] i_data,
    output logic       o_rd,
    output logic       o_uart_tx,
    output logic       o_busy
);

    localparam logic [UART_BAUD_W-1:0] ONE = 1;

    uart_state_t                 state;
    logic [UART_DATA_BITS-1:0]   shift;
    logic [2:0]                  index;
    logic                        tick;
    logic                        load;
`ifdef UART_TX_PARITY_EN
    logic                        parity_bit;
`endif

    // A pop happens only from IDLE or on the final cycle of a stop bit.
    assign o_rd   = !i_rst && i_empty_n && ((state == IDLE) || ((state == STOP) && tick));
    assign load   = o_rd || (tick && ((state == START) || (state == DATA) || (state == PARITY)));
    assign o_busy = (state != IDLE);

    uart_baud_counter #(
        .RELOAD (CLOCKS_PER_BAUD - ONE)
    ) u_baud (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (load),
        .o_tick (tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            o_uart_tx <= 1'b1;
            shift     <= 8'hff;
            index     <= 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (o_rd) begin
            state     <= START;
            o_uart_tx <= 1'b0;
            shift     <= i_data;
            index     <= 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^i_data;
`endif
        end else if (tick) begin
            case (state)
                START: begin
                    state     <= DATA;
                    index     <= 3'd0;
                    o_uart_tx <= shift[0];
                    shift     <= {1'b1, shift[7:1]};
                end
                DATA: begin
                    if (index != 3'd7) begin
                        index     <= index + 3'd1;
                        o_uart_tx <= shift[0];
                        shift     <= {1'b1, shift[7:1]};
                    end else begin
`ifdef UART_TX_PARITY_EN
                        state     <= PARITY;
                        o_uart_tx <= parity_bit;
`else
                        state     <= STOP;
                        o_uart_tx <= 1'b1;
`endif
                    end
                end
                PARITY: begin
                    state     <= STOP;
                    o_uart_tx <= 1'b1;
                end
                STOP: begin
                    // Refill case is taken by the o_rd branch above.
                    state     <= IDLE;
                    o_uart_tx <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    o_uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench for uart_tx_drain: table of byte vectors against a bit-time line model,
// plus idle, reset-mid-frame and (with UART_TX_PARITY_EN) parity sequences.
module tb_uart_tx_drain;

    localparam int CA = 8;
    localparam int CB = 2;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       empty_n_a, empty_n_b;
    logic [7:0] data_a, data_b;
    logic       rd_a, rd_b, tx_a, tx_b, busy_a, busy_b;

    always #5 clk = ~clk;

    uart_tx_drain #(.CLOCKS_PER_BAUD(24'd8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_empty_n(empty_n_a), .i_data(data_a),
        .o_rd(rd_a), .o_uart_tx(tx_a), .o_busy(busy_a)
    );

    uart_tx_drain #(.CLOCKS_PER_BAUD(24'd2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_empty_n(empty_n_b), .i_data(data_b),
        .o_rd(rd_b), .o_uart_tx(tx_b), .o_busy(busy_b)
    );

    typedef struct {
        int              sel;
        int              n;
        logic [2:0][7:0] b;
        int              exp_rd;
        int              exp_len;
    } vec_t;

    vec_t       vecs[7];
    int         checks   = 0;
    int         failures = 0;
    int         sel      = 0;
    logic [7:0] fifo_q[$];
    logic       tx_log[$];
    logic       rd_log[$];
    logic       busy_log[$];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int cpb(input int s);
        return (s != 0) ? CB : CA;
    endfunction

    // FIFO model: head byte visible to the selected DUT only.
    task automatic drive();
        empty_n_a = (sel == 0) && (fifo_q.size() != 0);
        empty_n_b = (sel == 1) && (fifo_q.size() != 0);
        data_a    = (sel == 0 && fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        data_b    = (sel == 1 && fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic step();
        logic r;
        @(negedge clk);
        r = (sel != 0) ? rd_b : rd_a;
        tx_log.push_back((sel != 0) ? tx_b : tx_a);
        rd_log.push_back(r);
        busy_log.push_back((sel != 0) ? busy_b : busy_a);
        @(posedge clk);
        #1;
        if (r && fifo_q.size() != 0) void'(fifo_q.pop_front());
        drive();
    endtask

    task automatic clear_logs();
        tx_log.delete();
        rd_log.delete();
        busy_log.delete();
    endtask

    // Frame bit k: start, eight data bits LSB first, optional even parity, stop.
    function automatic logic frame_bit(input logic [7:0] b8, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b8[k-1];
        if (FB == 11 && k == 9) return ^b8;
        return 1'b1;
    endfunction

    // Cycle 0 is the pop cycle; frames then follow each other every FB*C cycles.
    function automatic logic exp_tx(input logic [2:0][7:0] b, input int n, input int c, input int cc);
        int j, f;
        if (c == 0) return 1'b1;
        j = c - 1;
        f = j / (FB * cc);
        if (f >= n) return 1'b1;
        return frame_bit(b[f], (j % (FB * cc)) / cc);
    endfunction

    function automatic void decode(input int from, input int cc, output logic ok,
                                   output logic [7:0] d, output int next);
        ok   = 1'b0;
        d    = 8'h00;
        next = tx_log.size();
        for (int i = from; i + FB * cc <= tx_log.size(); i++) begin
            if (tx_log[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) d[k] = tx_log[i + cc * (k + 1) + cc / 2];
                ok   = 1'b1;
                next = i + (FB - 1) * cc + cc / 2;
                return;
            end
        end
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int cc, total, rd_cnt, rd_bad, tx_bad, busy_cnt, pos, nxt;
        logic ok;
        logic [7:0] d;
        logic exp_r;
        sel = v.sel;
        cc  = cpb(v.sel);
        for (int i = 0; i < v.n; i++) fifo_q.push_back(v.b[i]);
        drive();
        clear_logs();
        total = v.exp_len + 6;
        repeat (total) step();
        rd_cnt = 0; rd_bad = 0; tx_bad = 0; busy_cnt = 0;
        for (int c = 0; c < total; c++) begin
            exp_r = ((c % (FB * cc)) == 0) && ((c / (FB * cc)) < v.n);
            if (rd_log[c]) rd_cnt++;
            if (rd_log[c] != exp_r) rd_bad++;
            if (tx_log[c] != exp_tx(v.b, v.n, c, cc)) tx_bad++;
            if (busy_log[c]) busy_cnt++;
        end
        check($sformatf("v%0d_rd_count", idx), rd_cnt, v.exp_rd);
        check($sformatf("v%0d_rd_timing_errs", idx), rd_bad, 0);
        check($sformatf("v%0d_tx_wave_errs", idx), tx_bad, 0);
        check($sformatf("v%0d_busy_cycles", idx), busy_cnt, v.exp_len);
        check($sformatf("v%0d_idle_after", idx), int'(busy_log[total-1]), 0);
        pos = 0;
        for (int k = 0; k < v.n; k++) begin
            decode(pos, cc, ok, d, nxt);
            check($sformatf("v%0d_byte%0d", idx, k), ok ? int'(d) : -1, int'(v.b[k]));
            pos = nxt;
        end
    endtask

    initial begin
        int cnt_rd, cnt_low, cnt_busy, nxt;
        logic ok;
        logic [7:0] d;
        vec_t pv;

        // Vector table: fixed test-plan bytes plus random ones.
        vecs[0].sel = 0; vecs[0].n = 1; vecs[0].b = '0; vecs[0].b[0] = 8'h55;
        vecs[1].sel = 0; vecs[1].n = 3; vecs[1].b = '0;
        vecs[1].b[0] = 8'h00; vecs[1].b[1] = 8'hFF; vecs[1].b[2] = 8'hA3;
        vecs[2].sel = 1; vecs[2].n = 1; vecs[2].b = '0; vecs[2].b[0] = 8'h81;
        for (int i = 3; i < 7; i++) begin
            vecs[i].sel = $urandom_range(0, 1);
            vecs[i].n   = $urandom_range(1, 3);
            vecs[i].b   = 24'($urandom);
        end
        for (int i = 0; i < 7; i++) begin
            vecs[i].exp_rd  = vecs[i].n;
            vecs[i].exp_len = vecs[i].n * FB * cpb(vecs[i].sel);
        end

        // Reset with a byte waiting: no pop while reset is high.
        rst = 1'b1;
        sel = 0;
        fifo_q.push_back(8'h3C);
        drive();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_rd", int'(rd_a), 0);
        check("reset_tx", int'(tx_a), 1);
        check("reset_busy", int'(busy_a), 0);
        check("reset_rd_b", int'(rd_b), 0);
        check("reset_tx_b", int'(tx_b), 1);
        @(posedge clk);
        #1;
        fifo_q.delete();
        drive();
        rst = 1'b0;

        // Empty FIFO: line stays idle.
        clear_logs();
        repeat (100) step();
        cnt_rd = 0; cnt_low = 0; cnt_busy = 0;
        for (int c = 0; c < 100; c++) begin
            if (rd_log[c]) cnt_rd++;
            if (!tx_log[c]) cnt_low++;
            if (busy_log[c]) cnt_busy++;
        end
        check("idle_rd", cnt_rd, 0);
        check("idle_tx_low", cnt_low, 0);
        check("idle_busy", cnt_busy, 0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset 30 cycles into a frame with more bytes still queued.
        sel = 0;
        fifo_q.push_back(8'hC4);
        fifo_q.push_back(8'h5A);
        drive();
        repeat (30) step();
        clear_logs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (FB * CA + 8) step();
        check("midrst_rd_in_reset", int'(rd_log[0]), 0);
        check("midrst_tx_after", int'(tx_log[1]), 1);
        check("midrst_busy_after", int'(busy_log[1]), 0);
        check("midrst_pop_after", int'(rd_log[1]), 1);
        check("midrst_start_bit", int'(tx_log[2]), 0);
        decode(1, CA, ok, d, nxt);
        check("midrst_byte", ok ? int'(d) : -1, 32'h5A);
        check("midrst_fifo_left", fifo_q.size(), 0);

`ifdef UART_TX_PARITY_EN
        pv.sel = 0; pv.n = 2; pv.b = '0; pv.b[0] = 8'h07; pv.b[1] = 8'h03;
        pv.exp_rd = 2; pv.exp_len = 2 * 88;
        run_vec(7, pv);
        check("parity_bit0", int'(tx_log[1 + 9 * CA + CA / 2]), 1);
        check("parity_bit1", int'(tx_log[1 + 88 + 9 * CA + CA / 2]), 0);
        check("parity_second_pop", int'(rd_log[88]), 1);
`else
        pv.sel = 1; pv.n = 2; pv.b = '0; pv.b[0] = 8'h07; pv.b[1] = 8'h03;
        pv.exp_rd = 2; pv.exp_len = 2 * FB * CB;
        run_vec(7, pv);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- Read-side consumer of the UART transmit FIFO: pops bytes through the FIFO's empty_n/rd/data handshake and serialises each one onto the UART line as 8N1, LSB first.
- Sits between the TX FIFO and the board pin. It is the reader paired with the bus-side writer of the FIFO.
- Frames go out back to back, with no idle gap, while the FIFO stays non-empty.

Parameters:
- CLOCKS_PER_BAUD, 24'd868, clock cycles per bit (100 MHz / 115200). Legal range is 2 to 2^24-1.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous, active-high reset
- i_empty_n  input  1  FIFO holds at least one byte; i_data is valid
- i_data  input  8  FIFO head byte
- o_rd  output  1  pop strobe to FIFO; the byte on i_data is consumed on this edge
- o_uart_tx  output  1  serial line, idle high
- o_busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: state=IDLE, o_uart_tx=1, o_busy=0, baud counter=0, shift register=8'hff.
- States are IDLE, START, DATA, STOP. A bit index 0..7 is used in DATA.
- Baud counter: loads CLOCKS_PER_BAUD-1 at every bit start and counts down to 0. The "tick" is counter==0 and occurs once per bit. Counter is 24 bits wide; no wrap below 0.
- o_rd is combinational: (!i_rst) && i_empty_n && ((state==IDLE) || (state==STOP && tick)). It is never asserted while i_empty_n=0.
- On an o_rd edge:
  - shift register <= i_data
  - state <= START
  - o_uart_tx <= 0
  - counter <= CLOCKS_PER_BAUD-1
- Latency: the start bit appears on o_uart_tx the cycle after o_rd.
- START + tick: state <= DATA, index=0, o_uart_tx <= shift[0], shift register shifts right.
- DATA + tick:
  - index<7: drive the next bit and index++.
  - index==7: state <= STOP, o_uart_tx <= 1.
- STOP + tick:
  - i_empty_n=1: o_rd pops the next byte and the next start bit follows directly. Frame period is exactly 10*CLOCKS_PER_BAUD cycles.
  - otherwise: state <= IDLE, o_uart_tx stays 1.
- Every bit, including start and stop, lasts exactly CLOCKS_PER_BAUD cycles.
- o_uart_tx is driven from a register and is glitch-free.
- i_data and i_empty_n are ignored outside the o_rd cycle. A FIFO refilling mid-frame has no effect until the STOP tick.
- Reset mid-frame: the frame is abandoned. The line is high the next cycle, no o_rd, and the byte already popped is lost.
- Reset while i_empty_n=1: no pop occurs during the reset cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: an even-parity bit is inserted between DATA index 7 and STOP.
  - Adds a PARITY state; parity = ^byte, computed at load.
  - Frame = 11 bit times; back-to-back period = 11*CLOCKS_PER_BAUD.
- Undefined: no PARITY state and 8N1 as above.

Decomposition:
- Shared package uart_pkg holds:
  - state enum: IDLE, START, DATA, STOP, PARITY
  - UART_DATA_BITS=8
  - UART_BAUD_W=24
  - default CLOCKS_PER_BAUD constant
- One natural sub-module, uart_baud_counter: load/countdown with a tick output. It is reusable by the receiver.

Test Plan (CLOCKS_PER_BAUD=8 unless stated):
- FIFO holds 8'h55, i_empty_n held high one cycle then low:
  - o_rd is high exactly 1 cycle.
  - o_uart_tx reads 0,1,0,1,0,1,0,1,0,1, with each level lasting 8 cycles.
  - Line then idles high and o_busy=0 after 80 cycles.
- FIFO holds 8'h00, 8'hFF, 8'hA3 back to back:
  - Exactly 3 o_rd pulses, 80 cycles apart.
  - No high idle gap between the stop bit and the next start bit.
  - The decoded bytes match.
- i_empty_n=0 forever after reset: o_rd never asserts, o_uart_tx=1, o_busy=0.
- i_rst asserted at cycle 30 of a frame with i_empty_n=1:
  - The next cycle has o_uart_tx=1, o_busy=0, and no o_rd in the reset cycle.
  - The first post-reset cycle pops and a new start bit follows.
- CLOCKS_PER_BAUD=2 with 8'h81: bit widths are 2 cycles and the frame is 20 cycles.
- UART_TX_PARITY_EN defined, bytes 8'h07 then 8'h03:
  - Parity bits are 1 and 0.
  - Frame period is 88 cycles.
